// File: rtl/operand_sequencer_if.sv
// Instruction handshake, ALU operand/result buses, status pulses and debug port
// shared between the operand sequencer and its environment.
interface operand_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] a_bus;
  logic [15:0] b_bus;
  logic [2:0]  alu_opcode;
  logic [15:0] accumulator;
  logic        zero_flag;
  logic        z_flag;
  logic        done;
  logic        illegal;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  modport master (
    output instr_valid, instr, accumulator, zero_flag, dbg_addr,
    input  instr_ready, a_bus, b_bus, alu_opcode, z_flag, done, illegal, dbg_data
  );

  modport slave (
    input  instr_valid, instr, accumulator, zero_flag, dbg_addr,
    output instr_ready, a_bus, b_bus, alu_opcode, z_flag, done, illegal, dbg_data
  );
endinterface

// File: rtl/operand_sequencer.sv
// Operand fetch / writeback stage around a combinational ALU: owns the 8x16
// register file and runs one instruction at a time through IDLE-READ-EXEC-WRITE.
//
// state   | meaning
// IDLE    | ready for a new instruction, latches it on instr_valid
// READ    | drives ALU operands/opcode, or routes LDI / rejects illegal ops
// EXEC    | settling cycle for the ALU result
// WRITE   | commits result to rd and updates z_flag, pulses done
module operand_sequencer (
  input  logic                 clk,
  input  logic                 reset,
  operand_sequencer_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [2:0] OP_LDI = 3'b011;

  logic [1:0]  state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] rf_q [8];
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic        z_q, z_d;
  logic        done_q, done_d;
  logic        ill_q, ill_d;
  logic        wr_en;
  logic [15:0] wr_data;

  logic [2:0]  f_op, f_rd, f_rs1, f_rs2;
  logic [7:0]  f_imm;

  assign f_op  = instr_q[15:13];
  assign f_rd  = instr_q[12:10];
  assign f_rs1 = instr_q[9:7];
  assign f_rs2 = instr_q[6:4];
  assign f_imm = instr_q[7:0];

  function automatic logic [15:0] rf_read(input logic [2:0] addr);
    return (addr == 3'd0) ? 16'h0000 : rf_q[addr];
  endfunction

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    z_d     = z_q;
    done_d  = 1'b0;
    ill_d   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 16'h0000;
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (f_op == OP_LDI) begin
          state_d = S_WRITE;
        end else if (f_op[2]) begin
          ill_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          a_d     = rf_read(f_rs1);
          b_d     = rf_read(f_rs2);
          op_d    = f_op;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_WRITE;
      end
      default: begin
        // LDI bypasses the ALU, so its zero status is derived locally
        wr_en   = 1'b1;
        wr_data = (f_op == OP_LDI) ? {8'h00, f_imm} : bus.accumulator;
        z_d     = (f_op == OP_LDI) ? (f_imm == 8'h00) : bus.zero_flag;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      instr_q <= 16'h0000;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      op_q    <= 3'b000;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= 16'h0000;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      z_q     <= z_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
      if (wr_en && (f_rd != 3'd0)) rf_q[f_rd] <= wr_data;
    end
  end

  assign bus.instr_ready = (state_q == S_IDLE);
  assign bus.a_bus       = a_q;
  assign bus.b_bus       = b_q;
  assign bus.alu_opcode  = op_q;
  assign bus.z_flag      = z_q;
  assign bus.done        = done_q;
  assign bus.illegal     = ill_q;
  assign bus.dbg_data    = rf_read(bus.dbg_addr);

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer with a behavioural ALU looped back onto
// the accumulator / zero_flag inputs.
module tb_operand_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  operand_sequencer_if bif ();

  operand_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (bif.alu_opcode)
      3'b000:  bif.accumulator = bif.a_bus + bif.b_bus;
      3'b001:  bif.accumulator = bif.a_bus - bif.b_bus;
      3'b010:  bif.accumulator = bif.a_bus * bif.b_bus;
      default: bif.accumulator = 16'h0000;
    endcase
  end
  assign bif.zero_flag = (bif.accumulator == 16'h0000);

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {3'b011, rd, 2'b00, imm};
  endfunction

  function automatic logic [15:0] alu(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 4'h0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] addr, input logic [15:0] exp);
    bif.dbg_addr = addr;
    #1;
    chk(tag, {16'h0, bif.dbg_data}, {16'h0, exp});
  endtask

  // Issues one instruction and follows it to done/illegal (bounded). With hold
  // set, instr_valid stays high while busy and instr is swapped for another word.
  task automatic run_instr(input logic [15:0] w, input bit hold, input string tag,
                           output int lat, output int rdy_low,
                           output bit got_done, output bit got_ill);
    @(negedge clk);
    bif.instr_valid = 1'b1;
    bif.instr       = w;
    chk({tag, "_ready_at_issue"}, {31'h0, bif.instr_ready}, 32'd1);
    @(posedge clk); #1;
    if (hold) bif.instr = 16'h7C55;
    else      bif.instr_valid = 1'b0;
    lat = 0; rdy_low = 0; got_done = 1'b0; got_ill = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!bif.instr_ready) rdy_low++;
      if (bif.done || bif.illegal) begin
        got_done = bif.done;
        got_ill  = bif.illegal;
        bif.instr_valid = 1'b0;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    bif.instr_valid = 1'b0;
    chk({tag, "_completed"}, {31'h0, got_done | got_ill}, 32'd1);
    @(posedge clk); #1;
    chk({tag, "_pulse_one_cycle"}, {30'h0, bif.done, bif.illegal}, 32'd0);
  endtask

  task automatic exec_ok(input logic [15:0] w, input string tag, input int exp_lat);
    int lat, rl;
    bit d, il;
    run_instr(w, 1'b0, tag, lat, rl, d, il);
    chk({tag, "_done"}, {31'h0, d}, 32'd1);
    chk({tag, "_latency"}, lat, exp_lat);
  endtask

  initial begin
    int lat, rl, n;
    bit d, il;
    logic [15:0] exp_rf [8];
    checks = 0;
    failures = 0;
    bif.instr_valid = 1'b0;
    bif.instr       = 16'h0000;
    bif.dbg_addr    = 3'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",   {31'h0, bif.instr_ready}, 32'd1);
    chk("rst_a_bus",   {16'h0, bif.a_bus}, 32'h0);
    chk("rst_b_bus",   {16'h0, bif.b_bus}, 32'h0);
    chk("rst_opcode",  {29'h0, bif.alu_opcode}, 32'h0);
    chk("rst_flags",   {29'h0, bif.z_flag, bif.done, bif.illegal}, 32'h0);
    chk_reg("rst_r5", 3'd5, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // 1: LDI / ADD timing and result
    exec_ok(ldi(3'd1, 8'd5), "ldi_r1", 2);
    exec_ok(ldi(3'd2, 8'd3), "ldi_r2", 2);
    run_instr(alu(3'b000, 3'd3, 3'd1, 3'd2), 1'b0, "add_r3", lat, rl, d, il);
    chk("add_r3_done", {31'h0, d}, 32'd1);
    chk("add_r3_latency", lat, 3);
    chk("add_r3_ready_low", rl, 3);
    chk_reg("add_r3_val", 3'd3, 16'h0008);
    chk("add_r3_z", {31'h0, bif.z_flag}, 32'd0);
    chk("add_r3_a_bus", {16'h0, bif.a_bus}, 32'h5);
    chk("add_r3_b_bus", {16'h0, bif.b_bus}, 32'h3);

    // 2: SUB zero and wrap
    exec_ok(alu(3'b001, 3'd4, 3'd1, 3'd1), "sub_r4", 3);
    chk_reg("sub_r4_val", 3'd4, 16'h0000);
    chk("sub_r4_z", {31'h0, bif.z_flag}, 32'd1);
    exec_ok(alu(3'b001, 3'd5, 3'd2, 3'd1), "sub_r5", 3);
    chk_reg("sub_r5_val", 3'd5, 16'hFFFE);
    chk("sub_r5_z", {31'h0, bif.z_flag}, 32'd0);
    chk("sub_r5_opcode", {29'h0, bif.alu_opcode}, 32'h1);

    // 3: MUL with truncation
    exec_ok(ldi(3'd1, 8'hFF), "ldi_r1_ff", 2);
    exec_ok(alu(3'b010, 3'd5, 3'd1, 3'd1), "mul_r5", 3);
    chk_reg("mul_r5_val", 3'd5, 16'hFE01);
    exec_ok(alu(3'b010, 3'd6, 3'd5, 3'd5), "mul_r6", 3);
    chk_reg("mul_r6_val", 3'd6, 16'hFC01);

    // 4: r0 is hardwired to zero, but the write still completes
    exec_ok(alu(3'b001, 3'd4, 3'd1, 3'd1), "sub_r4_again", 3);
    chk("sub_r4_again_z", {31'h0, bif.z_flag}, 32'd1);
    exec_ok(ldi(3'd0, 8'd7), "ldi_r0", 2);
    chk_reg("ldi_r0_val", 3'd0, 16'h0000);
    chk("ldi_r0_z", {31'h0, bif.z_flag}, 32'd0);
    exec_ok(alu(3'b000, 3'd7, 3'd0, 3'd2), "add_r7", 3);
    chk_reg("add_r7_val", 3'd7, 16'h0003);
    chk("add_r7_a_bus", {16'h0, bif.a_bus}, 32'h0);
    chk("add_r7_b_bus", {16'h0, bif.b_bus}, 32'h3);

    // 5: illegal opcode leaves all state untouched
    exp_rf[0] = 16'h0000; exp_rf[1] = 16'h00FF; exp_rf[2] = 16'h0003; exp_rf[3] = 16'h0008;
    exp_rf[4] = 16'h0000; exp_rf[5] = 16'hFE01; exp_rf[6] = 16'hFC01; exp_rf[7] = 16'h0003;
    run_instr(alu(3'b101, 3'd1, 3'd2, 3'd2), 1'b0, "illegal", lat, rl, d, il);
    chk("illegal_pulse", {31'h0, il}, 32'd1);
    chk("illegal_no_done", {31'h0, d}, 32'd0);
    chk("illegal_latency", lat, 1);
    chk("illegal_z", {31'h0, bif.z_flag}, 32'd0);
    chk("illegal_a_bus", {16'h0, bif.a_bus}, 32'h0);
    for (int r = 0; r < 8; r++) chk_reg($sformatf("illegal_rf%0d", r), r[2:0], exp_rf[r]);

    // 5b: held instr_valid during a busy ADD; the swapped-in LDI r7 must not run
    run_instr(alu(3'b000, 3'd3, 3'd1, 3'd2), 1'b1, "busy_add", lat, rl, d, il);
    chk("busy_add_done", {31'h0, d}, 32'd1);
    chk("busy_add_latency", lat, 3);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bif.done || !bif.instr_ready) n++;
    end
    chk("busy_no_extra", n, 0);
    chk_reg("busy_add_r3", 3'd3, 16'h0102);
    chk_reg("busy_r7_kept", 3'd7, 16'h0003);

    // 6: reset during EXEC of ADD r3
    @(negedge clk);
    bif.instr_valid = 1'b1;
    bif.instr       = alu(3'b000, 3'd3, 3'd1, 3'd2);
    @(posedge clk); #1;
    bif.instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("exec_a_bus", {16'h0, bif.a_bus}, 32'hFF);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst2_ready",  {31'h0, bif.instr_ready}, 32'd1);
    chk("rst2_a_bus",  {16'h0, bif.a_bus}, 32'h0);
    chk("rst2_b_bus",  {16'h0, bif.b_bus}, 32'h0);
    chk("rst2_opcode", {29'h0, bif.alu_opcode}, 32'h0);
    chk("rst2_flags",  {29'h0, bif.z_flag, bif.done, bif.illegal}, 32'h0);
    chk_reg("rst2_r3", 3'd3, 16'h0000);
    chk_reg("rst2_r1", 3'd1, 16'h0000);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bif.done || bif.illegal || !bif.instr_ready) n++;
    end
    chk("rst2_quiet", n, 0);
    chk_reg("rst2_r3_after", 3'd3, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
